// File: rtl/ulpb_tx_arbiter.sv
// Shares one ULPB node transmit port among NUM_REQ requesters, holding each grant for a whole transaction.
// Define ULPB_ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default build uses round-robin.
module ulpb_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PEND,
  input  logic [NUM_REQ-1:0]            REQ_REQ,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  output logic [NUM_REQ-1:0]            REQ_SUCC,
  output logic [NUM_REQ-1:0]            REQ_FAIL,
  input  logic [NUM_REQ-1:0]            REQ_RESP_ACK,
  output logic [ADDR_WIDTH-1:0]         TX_ADDR,
  output logic [DATA_WIDTH-1:0]         TX_DATA,
  output logic                          TX_PEND,
  output logic                          TX_REQ,
  input  logic                          TX_ACK,
  input  logic                          TX_SUCC,
  input  logic                          TX_FAIL,
  output logic                          TX_RESP_ACK,
  output logic                          GRANT_VALID,
  output logic [IDX_W-1:0]              GRANT_IDX
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   grant_idx;
  logic               succ_q;
  logic               fail_q;
  logic               resp_ack_q;
`ifndef ULPB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_idx;
`endif

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_pend;
  logic                  sel_req;
  logic                  sel_resp_ack;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic [IDX_W-1:0]      winner;
  logic                  any_req;

  // Fields of whichever requester grant_idx points at; valid in every state.
  always_comb begin
    // NOTE: each signal gets a default before the loop so no path leaves it unassigned (no latch).
    sel_addr     = '0;
    sel_data     = '0;
    sel_pend     = 1'b0;
    sel_req      = 1'b0;
    sel_resp_ack = 1'b0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr        = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data        = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_pend        = REQ_PEND[i];
        sel_req         = REQ_REQ[i];
        sel_resp_ack    = REQ_RESP_ACK[i];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  assign any_req = |REQ_REQ;

`ifdef ULPB_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (REQ_REQ[i]) winner = IDX_W'(i);
    end
  end
`else
  // Round-robin: the lowest requester above last_idx wins, otherwise wrap to the lowest overall.
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic             hi_found;

  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (REQ_REQ[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) > last_idx) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end
`endif

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
    if (RESET) begin
      state      <= IDLE;
      grant_idx  <= '0;
      succ_q     <= 1'b0;
      fail_q     <= 1'b0;
      resp_ack_q <= 1'b0;
`ifndef ULPB_ARB_FIXED_PRIO_EN
      last_idx   <= IDX_W'(NUM_REQ-1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= winner;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // The result ends the grant even if the requester still holds REQ (underflow / receiver reset).
          if (TX_SUCC || TX_FAIL) begin
            succ_q <= TX_SUCC;
            fail_q <= TX_FAIL;
            state  <= RESP;
          end
        end
        RESP: begin
          if (sel_resp_ack) begin
            succ_q     <= 1'b0;
            fail_q     <= 1'b0;
            resp_ack_q <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (!TX_SUCC && !TX_FAIL) begin
            resp_ack_q <= 1'b0;
`ifndef ULPB_ARB_FIXED_PRIO_EN
            last_idx   <= grant_idx;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign TX_ADDR     = sel_addr;
  assign TX_DATA     = sel_data;
  assign TX_PEND     = sel_pend;
  assign TX_REQ      = (state == BUSY) && sel_req;
  assign REQ_ACK     = ((state == BUSY) && TX_ACK) ? grant_onehot : '0;
  assign REQ_SUCC    = ((state == RESP) && succ_q) ? grant_onehot : '0;
  assign REQ_FAIL    = ((state == RESP) && fail_q) ? grant_onehot : '0;
  assign TX_RESP_ACK = resp_ack_q;
  assign GRANT_VALID = (state != IDLE);
  assign GRANT_IDX   = grant_idx;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Directed bench for ulpb_tx_arbiter: a transaction-level model checked every cycle, plus literal checkpoints.
// Honours ULPB_ARB_FIXED_PRIO_EN the same way as the design.
module tb_ulpb_tx_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_pend, req_req, req_resp_ack;
  logic [N-1:0]    req_ack, req_succ, req_fail;
  logic [AW-1:0]   tx_addr;
  logic [DW-1:0]   tx_data;
  logic            tx_pend, tx_req, tx_ack, tx_succ, tx_fail, tx_resp_ack;
  logic            grant_valid;
  logic [1:0]      grant_idx;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  ulpb_tx_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(clk), .RESET(rst),
    .REQ_ADDR(req_addr), .REQ_DATA(req_data), .REQ_PEND(req_pend), .REQ_REQ(req_req),
    .REQ_ACK(req_ack), .REQ_SUCC(req_succ), .REQ_FAIL(req_fail), .REQ_RESP_ACK(req_resp_ack),
    .TX_ADDR(tx_addr), .TX_DATA(tx_data), .TX_PEND(tx_pend), .TX_REQ(tx_req),
    .TX_ACK(tx_ack), .TX_SUCC(tx_succ), .TX_FAIL(tx_fail), .TX_RESP_ACK(tx_resp_ack),
    .GRANT_VALID(grant_valid), .GRANT_IDX(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic p, input logic r);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_pend[i]          = p;
    req_req[i]           = r;
  endtask

  // ---------------- transaction-level model ----------------
  int owner = -1;      // requester holding the grant, -1 when free
  int shown = 0;       // requester whose fields appear on the TX side
  int last  = N-1;     // previous owner, for round-robin
  bit has_result = 1'b0, res_succ = 1'b0, res_fail = 1'b0, acking = 1'b0;
  bit busy;

  function automatic int pick(input logic [N-1:0] r, input int lst);
`ifdef ULPB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(lst+k)%N]) return (lst+k)%N;
`endif
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      owner <= -1; shown <= 0; last <= N-1;
      has_result <= 1'b0; res_succ <= 1'b0; res_fail <= 1'b0; acking <= 1'b0;
    end else if (owner < 0) begin
      if (req_req != '0) begin
        owner <= pick(req_req, last);
        shown <= pick(req_req, last);
      end
    end else if (!has_result && !acking) begin
      if (tx_succ || tx_fail) begin
        has_result <= 1'b1; res_succ <= tx_succ; res_fail <= tx_fail;
      end
    end else if (has_result) begin
      if (req_resp_ack[shown]) begin
        has_result <= 1'b0; acking <= 1'b1;
      end
    end else if (!tx_succ && !tx_fail) begin
      acking <= 1'b0; last <= owner; owner <= -1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      busy = (owner >= 0) && !has_result && !acking;
      check("m_grant_valid", 64'(grant_valid), 64'(owner >= 0));
      check("m_grant_idx", 64'(grant_idx), 64'(shown));
      check("m_tx_addr", 64'(tx_addr), 64'(req_addr[shown*AW +: AW]));
      check("m_tx_data", 64'(tx_data), 64'(req_data[shown*DW +: DW]));
      check("m_tx_pend", 64'(tx_pend), 64'(req_pend[shown]));
      check("m_tx_req", 64'(tx_req), 64'(busy && req_req[shown]));
      check("m_req_ack", 64'(req_ack), (busy && tx_ack) ? (64'(1) << shown) : 64'(0));
      check("m_req_succ", 64'(req_succ), (has_result && res_succ) ? (64'(1) << shown) : 64'(0));
      check("m_req_fail", 64'(req_fail), (has_result && res_fail) ? (64'(1) << shown) : 64'(0));
      check("m_tx_resp_ack", 64'(tx_resp_ack), 64'(acking));
    end
  end

  // One complete single-word transaction for whichever requester gets granted; reports the grant.
  task automatic serve(output int g);
    int n = 0;
    while (tx_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("serve_wait_tx_req", 64'(tx_req), 64'(1));
    g = int'(grant_idx);
    tx_ack = 1'b1;
    tick();
    tx_ack  = 1'b0;
    tx_succ = 1'b1;
    tick();
    req_resp_ack    = '0;
    req_resp_ack[g] = 1'b1;
    tick();
    req_resp_ack = '0;
    tx_succ      = 1'b0;
    tick();
  endtask

  int g;
  int exp_rr[4];

  initial begin
    rst = 1'b1;
    req_addr = '0; req_data = '0; req_pend = '0; req_req = '0; req_resp_ack = '0;
    tx_ack = 1'b0; tx_succ = 1'b0; tx_fail = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_grant_valid", 64'(grant_valid), 64'(0));
    check("rst_grant_idx", 64'(grant_idx), 64'(0));
    check("rst_tx_req", 64'(tx_req), 64'(0));
    check("rst_tx_resp_ack", 64'(tx_resp_ack), 64'(0));
    rst = 1'b0;
    tick();

    // Single word from requester 2
    set_req(2, 8'h35, 32'hDEADBEEF, 1'b0, 1'b1);
    #1;
    check("single_tx_req_before_grant", 64'(tx_req), 64'(0));
    tick();
    check("single_tx_req", 64'(tx_req), 64'(1));
    check("single_grant_idx", 64'(grant_idx), 64'(2));
    check("single_tx_addr", 64'(tx_addr), 64'h35);
    check("single_tx_data", 64'(tx_data), 64'hDEADBEEF);
    tx_ack = 1'b1;
    #1;
    check("single_req_ack", 64'(req_ack), 64'b0100);
    tick();
    req_req[2] = 1'b0;
    tick();
    tx_ack  = 1'b0;
    tx_succ = 1'b1;
    #1;
    check("single_succ_not_yet", 64'(req_succ), 64'(0));
    tick();
    check("single_req_succ", 64'(req_succ), 64'b0100);
    req_resp_ack[2] = 1'b1;
    #1;
    check("single_resp_ack_not_yet", 64'(tx_resp_ack), 64'(0));
    tick();
    req_resp_ack = '0;
    check("single_tx_resp_ack", 64'(tx_resp_ack), 64'(1));
    tick();
    check("single_tx_resp_ack_held", 64'(tx_resp_ack), 64'(1));
    tx_succ = 1'b0;
    tick();
    check("single_back_idle", 64'(grant_valid), 64'(0));
    check("single_resp_ack_drop", 64'(tx_resp_ack), 64'(0));

    // Requesters 0 and 1 request continuously
`ifdef ULPB_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 0, 1};
`endif
    set_req(0, 8'h10, 32'h0000_0A0A, 1'b0, 1'b1);
    set_req(1, 8'h11, 32'h0000_0B0B, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      serve(g);
      check($sformatf("rr_grant_%0d", t), 64'(g), 64'(exp_rr[t]));
    end
    req_req = '0;

    // Pended burst on requester 1 while requester 3 waits
    set_req(1, 8'h40, 32'h0000_1000, 1'b1, 1'b1);
    tick();
    check("burst_grant_first", 64'(grant_idx), 64'(1));
    set_req(3, 8'h77, 32'h3333_3333, 1'b0, 1'b1);
    for (int w = 0; w < 3; w++) begin
      int n = 0;
      set_req(1, 8'(8'h40 + w), 32'(32'h1000 + w), (w < 2), 1'b1);
      #1;
      while (tx_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check($sformatf("burst_word%0d_grant", w), 64'(grant_idx), 64'(1));
      check($sformatf("burst_word%0d_data", w), 64'(tx_data), 64'(32'h1000 + w));
      check($sformatf("burst_word%0d_pend", w), 64'(tx_pend), 64'(w < 2));
      tx_ack = 1'b1;
      #1;
      check($sformatf("burst_word%0d_ack", w), 64'(req_ack), 64'b0010);
      tick();
      req_req[1] = 1'b0;
      tick();
      tx_ack = 1'b0;
      tick();
    end
    tx_succ = 1'b1;
    tick();
    check("burst_req_succ", 64'(req_succ), 64'b0010);
    req_resp_ack[1] = 1'b1;
    tick();
    req_resp_ack = '0;
    check("burst_drain_grant", 64'(grant_idx), 64'(1));
    check("burst_drain_no_tx_req", 64'(tx_req), 64'(0));
    tx_succ = 1'b0;
    tick();
    check("burst_idle_gap", 64'(grant_valid), 64'(0));
    tick();
    check("burst_next_grant", 64'(grant_idx), 64'(3));
    serve(g);
    check("burst_req3_served", 64'(g), 64'(3));
    req_req = '0;

    // Failure while the requester still holds REQ
    set_req(0, 8'h05, 32'h0BAD_0BAD, 1'b0, 1'b1);
    tick();
    check("fail_tx_req_up", 64'(tx_req), 64'(1));
    tx_fail = 1'b1;
    tick();
    check("fail_tx_req_drop", 64'(tx_req), 64'(0));
    check("fail_req_fail", 64'(req_fail), 64'b0001);
    check("fail_req_succ", 64'(req_succ), 64'(0));
    req_resp_ack[0] = 1'b1;
    tick();
    req_resp_ack = '0;
    tx_fail      = 1'b0;
    req_req      = '0;
    tick();

    // Foreign response ack during RESP with grant 2
    set_req(2, 8'h22, 32'h2222_2222, 1'b0, 1'b1);
    tick();
    check("foreign_grant", 64'(grant_idx), 64'(2));
    tx_succ = 1'b1;
    tick();
    req_resp_ack = 4'b0010;
    tick();
    check("foreign_no_resp_ack", 64'(tx_resp_ack), 64'(0));
    check("foreign_still_succ", 64'(req_succ), 64'b0100);
    req_resp_ack = '0;
    tick();
    check("foreign_still_valid", 64'(grant_valid), 64'(1));
    req_resp_ack = 4'b0100;
    tick();
    req_resp_ack = '0;
    req_req      = '0;
    tx_succ      = 1'b0;
    tick();

    // Make requester 0 the last owner, then reset in the middle of a burst from requester 1
    set_req(0, 8'h01, 32'h0000_0001, 1'b0, 1'b1);
    serve(g);
    req_req = '0;
    check("pre_reset_grant0", 64'(g), 64'(0));
    set_req(1, 8'h61, 32'h6161_6161, 1'b1, 1'b1);
    tick();
    check("reset_pre_grant", 64'(grant_idx), 64'(1));
    tx_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("reset_tx_req", 64'(tx_req), 64'(0));
    check("reset_req_ack", 64'(req_ack), 64'(0));
    check("reset_grant_valid", 64'(grant_valid), 64'(0));
    check("reset_grant_idx", 64'(grant_idx), 64'(0));
    check("reset_tx_resp_ack", 64'(tx_resp_ack), 64'(0));
    rst    = 1'b0;
    tx_ack = 1'b0;
    req_req[0] = 1'b1;
    tick();
    check("reset_first_grant", 64'(grant_idx), 64'(0));
    serve(g);
    req_req = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
